// File: rtl/vga_mon_pkg.sv
// Shared timing defaults, error-code bit positions and monitor state type for the VGA timing monitor.
package vga_mon_pkg;
  localparam int DEF_CLK_PER_PIX = 2;
  localparam int DEF_H_VISIBLE   = 640;
  localparam int DEF_H_FRONT     = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BACK      = 48;
  localparam int DEF_V_VISIBLE   = 480;
  localparam int DEF_V_FRONT     = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BACK      = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_HP      = DEF_H_TOTAL * DEF_CLK_PER_PIX;
  localparam int DEF_HW      = DEF_H_SYNC * DEF_CLK_PER_PIX;

  localparam int POS_W = 10;
  localparam int ERR_W = 3;
  localparam int CNT_W = 16;

  localparam int ERR_HPER = 0;
  localparam int ERR_HWID = 1;
  localparam int ERR_VERT = 2;

  typedef enum logic [1:0] {SEEK, TRAIN, LOCKED} mon_state_t;
endpackage

// File: rtl/vga_timing_monitor_if.sv
// Sync lines under test plus the monitor's lock/position/error reporting.
interface vga_timing_monitor_if;
  import vga_mon_pkg::*;
  logic             vga_hs_i;
  logic             vga_vs_i;
  logic             locked_o;
  logic             de_o;
  logic [POS_W-1:0] x_o;
  logic [POS_W-1:0] y_o;
  logic             frame_o;
  logic             err_o;
  logic [ERR_W-1:0] err_code_o;
  logic [CNT_W-1:0] err_cnt_o;

  modport master (output vga_hs_i, vga_vs_i,
                  input  locked_o, de_o, x_o, y_o, frame_o, err_o, err_code_o, err_cnt_o);
  modport slave  (input  vga_hs_i, vga_vs_i,
                  output locked_o, de_o, x_o, y_o, frame_o, err_o, err_code_o, err_cnt_o);
endinterface

// File: rtl/vga_timing_monitor_sync_edge_det.sv
// Normalises a sync line to active-high and emits assert/deassert edge pulses.
// VGA_MON_INPUT_SYNC_EN adds a 2-flop synchroniser ahead of the edge detector.
module sync_edge_det #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sync_in,
  output logic assert_edge,
  output logic deassert_edge
);
  logic act_in, act_q;

`ifdef VGA_MON_INPUT_SYNC_EN
  logic [1:0] meta;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) meta <= '0;
    else          meta <= {meta[0], sync_in ^ ACTIVE_LOW};
  end
  assign act_in = meta[1];
`else
  assign act_in = sync_in ^ ACTIVE_LOW;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) act_q <= 1'b0;
    else          act_q <= act_in;
  end

  assign assert_edge   = act_in & ~act_q;
  assign deassert_edge = ~act_in & act_q;
endmodule

// File: rtl/vga_timing_monitor.sv
// Checks incoming hs/vs against nominal timing, tracks lock and recovers x/y/de.
// Optional input synchroniser: VGA_MON_INPUT_SYNC_EN (adds 2 cycles to every response).
module vga_timing_monitor
  import vga_mon_pkg::*;
#(
  parameter int CLK_PER_PIX     = DEF_CLK_PER_PIX,
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  vga_timing_monitor_if.slave bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HP      = H_TOTAL * CLK_PER_PIX;
  localparam int HW      = H_SYNC * CLK_PER_PIX;
  localparam int HCNT_W  = $clog2(HP + 1);
  localparam int DE_H0   = (H_SYNC + H_BACK) * CLK_PER_PIX;
  localparam int DE_H1   = DE_H0 + H_VISIBLE * CLK_PER_PIX;
  localparam int DE_L0   = V_SYNC + V_BACK;
  localparam int DE_L1   = DE_L0 + V_VISIBLE;

  logic hs_rise, hs_fall, vs_rise, vs_fall;

  sync_edge_det #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sync_in(bus.vga_hs_i),
    .assert_edge(hs_rise), .deassert_edge(hs_fall));
  sync_edge_det #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sync_in(bus.vga_vs_i),
    .assert_edge(vs_rise), .deassert_edge(vs_fall));

  logic [HCNT_W-1:0] hcnt, hoff;
  logic [POS_W-1:0]  lcnt, lcnt_inc, lcnt_at_vs_fall;
  logic [ERR_W-1:0]  viol, err_code;
  logic [CNT_W-1:0]  err_cnt;
  logic              err_fire, de_nxt, locked, de, frame, err;
  logic [POS_W-1:0]  x_nxt, y_nxt, x, y;
  mon_state_t        state, state_nxt;

  assign lcnt_inc = (lcnt == '1) ? lcnt : lcnt + POS_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hcnt <= '0;
      lcnt <= '0;
    end else begin
      if (hs_rise)           hcnt <= '0;
      else if (hcnt != '1)   hcnt <= hcnt + HCNT_W'(1);
      if (vs_rise)           lcnt <= '0;
      else if (hs_rise)      lcnt <= lcnt_inc;
    end
  end

  // vs normally drops on an hs edge, so count the line that edge opens
  assign lcnt_at_vs_fall = hs_rise ? lcnt_inc : lcnt;

  always_comb begin
    viol = '0;
    if (hs_rise ? (hcnt != HCNT_W'(HP - 1)) : (hcnt == HCNT_W'(HP - 1)))
      viol[ERR_HPER] = 1'b1;
    if (hs_fall && hcnt != HCNT_W'(HW - 1))
      viol[ERR_HWID] = 1'b1;
    if (vs_rise && lcnt != POS_W'(V_TOTAL - 1))
      viol[ERR_VERT] = 1'b1;
    if (vs_fall && lcnt_at_vs_fall != POS_W'(V_SYNC))
      viol[ERR_VERT] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEEK:    if (vs_rise) state_nxt = TRAIN;
      TRAIN:   if (|viol) state_nxt = SEEK;
               else if (vs_rise) state_nxt = LOCKED;
      LOCKED:  if (|viol) state_nxt = SEEK;
      default: state_nxt = SEEK;
    endcase
  end

  assign err_fire = (state == LOCKED) && (|viol);
  assign hoff     = hcnt - HCNT_W'(DE_H0);
  assign de_nxt   = (state_nxt == LOCKED) &&
                    hcnt >= HCNT_W'(DE_H0) && hcnt < HCNT_W'(DE_H1) &&
                    lcnt >= POS_W'(DE_L0)  && lcnt < POS_W'(DE_L1);
  assign x_nxt    = POS_W'(hoff / HCNT_W'(CLK_PER_PIX));
  assign y_nxt    = lcnt - POS_W'(DE_L0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= SEEK;
      locked   <= 1'b0;
      frame    <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
      err_cnt  <= '0;
      de       <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else begin
      state  <= state_nxt;
      locked <= (state_nxt == LOCKED);
      frame  <= vs_rise;
      err    <= err_fire;
      if (err_fire) begin
        err_code <= viol;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
      de <= de_nxt;
      x  <= de_nxt ? x_nxt : '0;
      y  <= de_nxt ? y_nxt : '0;
    end
  end

  assign bus.locked_o   = locked;
  assign bus.frame_o    = frame;
  assign bus.err_o      = err;
  assign bus.err_code_o = err_code;
  assign bus.err_cnt_o  = err_cnt;
  assign bus.de_o       = de;
  assign bus.x_o        = x;
  assign bus.y_o        = y;
endmodule
